// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_bank
// Brief    : Bank of N_CH independent programmable clock dividers. Each
//            channel emits a near-50% duty divided clock and a one-cycle
//            tick on the last cycle of every period. Divisor updates are
//            held in a shadow register and applied only at period
//            boundaries; a shared sync input restarts all enabled channels.
// Revision : 1.0 - initial release, successor to the fixed 1 Hz divider
// ============================================================================
module clk_div_bank #(
  parameter int N_CH      = 4,
  parameter int W         = 32,
  parameter int DIV_RESET = 100_000_000,
  parameter int CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] en,
  input  logic            sync,
  input  logic            div_wr,
  input  logic [CW-1:0]   div_ch,
  input  logic [W-1:0]    div_data,
  output logic [N_CH-1:0] clk_out,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] pend
);

  localparam logic [W-1:0] C_DIV_RESET = W'(DIV_RESET);
  localparam logic [W-1:0] C_ONE       = W'(1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [W-1:0] r_count;
    logic [W-1:0] r_d_act;
    logic [W-1:0] r_d_sh;
    logic         r_pend;
    logic         r_en_q;
    logic         r_clk;
    logic         r_tick;

    logic [W-1:0] w_count_nx;
    logic [W-1:0] w_d_act_nx;
    logic [W-1:0] w_d_sh_nx;
    logic         w_pend_nx;
    logic [W:0]   w_sum_nx;
    logic [W-1:0] w_half_nx;
    logic         w_hit;
    logic         w_restart;
    logic         w_wrap;

    // Write decode; zero divisors are dropped so D_act can never become 0.
    assign w_hit = div_wr && (div_data != '0) && (div_ch == CW'(i));

    // A channel that was idle last cycle restarts at count 0, like sync.
    assign w_restart = sync || !r_en_q;
    assign w_wrap    = (r_count == (r_d_act - C_ONE));

    // Next-state for counter and divisor pair, period-boundary gated.
    always_comb begin
      w_count_nx = r_count + C_ONE;
      w_d_act_nx = r_d_act;
      w_d_sh_nx  = r_d_sh;
      w_pend_nx  = r_pend;
      if (!en[i] || w_restart || w_wrap) begin
        // Period boundary (or idle): commit any pending divisor, and let a
        // same-cycle write bypass the shadow and take effect immediately.
        w_count_nx = '0;
        if (r_pend) begin
          w_d_act_nx = r_d_sh;
          w_pend_nx  = 1'b0;
        end
        if (w_hit) begin
          w_d_act_nx = div_data;
          w_d_sh_nx  = div_data;
          w_pend_nx  = 1'b0;
        end
      end else if (w_hit) begin
        // Mid-period: only the last write before the wrap survives.
        w_d_sh_nx = div_data;
        w_pend_nx = 1'b1;
      end
    end

    // ceil(D/2) computed one bit wider so D = 2^W-1 does not wrap.
    assign w_sum_nx  = {1'b0, w_d_act_nx} + {{W{1'b0}}, 1'b1};
    assign w_half_nx = w_sum_nx[W:1];

    // State and registered outputs, derived from next-state to avoid lag.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_count <= '0;
        r_d_act <= C_DIV_RESET;
        r_d_sh  <= C_DIV_RESET;
        r_pend  <= 1'b0;
        r_en_q  <= 1'b0;
        r_clk   <= 1'b0;
        r_tick  <= 1'b0;
      end else begin
        r_count <= w_count_nx;
        r_d_act <= w_d_act_nx;
        r_d_sh  <= w_d_sh_nx;
        r_pend  <= w_pend_nx;
        r_en_q  <= en[i];
        r_clk   <= en[i] && (w_count_nx >= w_half_nx);
        r_tick  <= en[i] && (w_count_nx == (w_d_act_nx - C_ONE));
      end
    end

    assign clk_out[i] = r_clk;
    assign tick[i]    = r_tick;
    assign pend[i]    = r_pend;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_bank
// Brief    : Self-checking bench for clk_div_bank (4 channels, DIV_RESET=6).
//            Expected per-cycle outputs are queued as stimulus is applied
//            and compared after each active edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int DIVR = 6;
  localparam int CW   = 2;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] en;
  logic            sync;
  logic            div_wr;
  logic [CW-1:0]   div_ch;
  logic [W-1:0]    div_data;
  logic [N_CH-1:0] clk_out;
  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] pend;

  typedef struct packed {
    logic [N_CH-1:0] c;
    logic [N_CH-1:0] t;
    logic [N_CH-1:0] p;
  } exp_t;

  exp_t q[$];
  exp_t e;
  exp_t got;
  int   checks = 0;
  int   passed = 0;

  clk_div_bank #(.N_CH(N_CH), .W(W), .DIV_RESET(DIVR), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .div_wr(div_wr),
    .div_ch(div_ch), .div_data(div_data), .clk_out(clk_out), .tick(tick),
    .pend(pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Expected waveform of one channel at phase k of a period of d cycles.
  function automatic exp_t put(exp_t e_in, int ch, int d, int k);
    exp_t r;
    r = e_in;
    r.c[ch] = (k >= (d + 1) / 2);
    r.t[ch] = (k == d - 1);
    return r;
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int ch, input int d);
    div_wr   = 1'b1;
    div_ch   = CW'(ch);
    div_data = W'(d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = '0; sync = 1'b0; div_wr = 1'b0; div_ch = '0; div_data = '0;
    advance(); advance();
    checks++; if (clk_out !== 4'b0) $display("FAIL reset_clk got=%b want=0000", clk_out); else passed++;
    checks++; if (tick !== 4'b0) $display("FAIL reset_tick got=%b want=0000", tick); else passed++;
    checks++; if (pend !== 4'b0) $display("FAIL reset_pend got=%b want=0000", pend); else passed++;
    rst_n = 1'b1;
    en    = 4'b0001;
    for (int k = 0; k < 18; k++) begin
      q.push_back(put('0, 0, DIVR, k % DIVR));
      advance();
      got = q.pop_front(); checks++;
      if ({clk_out, tick, pend} !== got)
        $display("FAIL reset_div6 k=%0d got c=%b t=%b p=%b want c=%b t=%b p=%b", k, clk_out, tick, pend, got.c, got.t, got.p);
      else passed++;
    end
  endtask

  task automatic test_odd_divisors();
    en = '0;
    write(1, 5);
    for (int k = 0; k < 2; k++) begin
      q.push_back('0);
      advance();
      got = q.pop_front(); checks++;
      if ({clk_out, tick, pend} !== got)
        $display("FAIL odd_disabled_wr k=%0d got c=%b t=%b p=%b want all 0", k, clk_out, tick, pend);
      else passed++;
      write(2, 1);
    end
    div_wr = 1'b0;
    en     = 4'b0110;
    for (int k = 0; k < 15; k++) begin
      e = put('0, 1, 5, k % 5);
      e = put(e, 2, 1, 0);
      q.push_back(e);
      advance();
      got = q.pop_front(); checks++;
      if ({clk_out, tick, pend} !== got)
        $display("FAIL odd_div5_div1 k=%0d got c=%b t=%b p=%b want c=%b t=%b p=%b", k, clk_out, tick, pend, got.c, got.t, got.p);
      else passed++;
    end
  endtask

  task automatic test_mid_period();
    en = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      e = put('0, 0, 6, k);
      e.p[0] = (k >= 3);
      q.push_back(e);
      advance();
      got = q.pop_front(); checks++;
      if ({clk_out, tick, pend} !== got)
        $display("FAIL mid_old_period k=%0d got c=%b t=%b p=%b want c=%b t=%b p=%b", k, clk_out, tick, pend, got.c, got.t, got.p);
      else passed++;
      if (k == 2) write(0, 4);
      if (k == 3) div_wr = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      q.push_back(put('0, 0, 4, k % 4));
      advance();
      got = q.pop_front(); checks++;
      if ({clk_out, tick, pend} !== got)
        $display("FAIL mid_new_period k=%0d got c=%b t=%b p=%b want c=%b t=%b p=%b", k, clk_out, tick, pend, got.c, got.t, got.p);
      else passed++;
    end
  endtask

  task automatic test_wrap_write();
    // Last sample was the tick of a D=4 period: these writes hit the wrap.
    write(0, 6);
    for (int k = 0; k < 6; k++) begin
      q.push_back(put('0, 0, 6, k));
      advance();
      got = q.pop_front(); checks++;
      if ({clk_out, tick, pend} !== got)
        $display("FAIL wrap_bypass6 k=%0d got c=%b t=%b p=%b want c=%b t=%b p=%b", k, clk_out, tick, pend, got.c, got.t, got.p);
      else passed++;
      if (k == 0) div_wr = 1'b0;
      if (k == 5) write(0, 3);
    end
    for (int k = 0; k < 6; k++) begin
      q.push_back(put('0, 0, 3, k % 3));
      advance();
      got = q.pop_front(); checks++;
      if ({clk_out, tick, pend} !== got)
        $display("FAIL wrap_bypass3 k=%0d got c=%b t=%b p=%b want c=%b t=%b p=%b", k, clk_out, tick, pend, got.c, got.t, got.p);
      else passed++;
      if (k == 0) div_wr = 1'b0;
    end
    write(0, 0);
    for (int k = 0; k < 9; k++) begin
      q.push_back(put('0, 0, 3, k % 3));
      advance();
      got = q.pop_front(); checks++;
      if ({clk_out, tick, pend} !== got)
        $display("FAIL zero_write_ignored k=%0d got c=%b t=%b p=%b want c=%b t=%b p=%b", k, clk_out, tick, pend, got.c, got.t, got.p);
      else passed++;
    end
    div_wr = 1'b0;
  endtask

  task automatic test_sync();
    en = '0;
    write(0, 4);
    for (int k = 0; k < 2; k++) begin
      q.push_back('0);
      advance();
      got = q.pop_front(); checks++;
      if ({clk_out, tick, pend} !== got)
        $display("FAIL sync_setup k=%0d got c=%b t=%b p=%b want all 0", k, clk_out, tick, pend);
      else passed++;
      write(1, 8);
    end
    div_wr = 1'b0;
    en     = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      q.push_back(put('0, 0, 4, k));
      advance();
      got = q.pop_front(); checks++;
      if ({clk_out, tick, pend} !== got)
        $display("FAIL sync_ch0_lead k=%0d got c=%b t=%b p=%b want c=%b t=%b p=%b", k, clk_out, tick, pend, got.c, got.t, got.p);
      else passed++;
    end
    en = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      q.push_back(put(put('0, 0, 4, (2 + k) % 4), 1, 8, k));
      advance();
      got = q.pop_front(); checks++;
      if ({clk_out, tick, pend} !== got)
        $display("FAIL sync_skewed k=%0d got c=%b t=%b p=%b want c=%b t=%b p=%b", k, clk_out, tick, pend, got.c, got.t, got.p);
      else passed++;
    end
    sync = 1'b1;
    for (int k = 0; k < 16; k++) begin
      q.push_back(put(put('0, 0, 4, k % 4), 1, 8, k % 8));
      advance();
      got = q.pop_front(); checks++;
      if ({clk_out, tick, pend} !== got)
        $display("FAIL sync_aligned k=%0d got c=%b t=%b p=%b want c=%b t=%b p=%b", k, clk_out, tick, pend, got.c, got.t, got.p);
      else passed++;
      if (k == 0) sync = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    en = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      e = put('0, 0, 4, k);
      e.p[0] = (k == 1);
      q.push_back(e);
      advance();
      got = q.pop_front(); checks++;
      if ({clk_out, tick, pend} !== got)
        $display("FAIL areset_pend k=%0d got c=%b t=%b p=%b want c=%b t=%b p=%b", k, clk_out, tick, pend, got.c, got.t, got.p);
      else passed++;
      if (k == 0) write(0, 5);
      if (k == 1) div_wr = 1'b0;
    end
    // Half-period high from phase 2 so the drop is visible without a clock.
    advance();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (clk_out !== 4'b0) $display("FAIL areset_clk got=%b want=0000", clk_out); else passed++;
    checks++; if (tick !== 4'b0) $display("FAIL areset_tick got=%b want=0000", tick); else passed++;
    checks++; if (pend !== 4'b0) $display("FAIL areset_pend_clr got=%b want=0000", pend); else passed++;
    advance();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      q.push_back(put('0, 0, DIVR, k % DIVR));
      advance();
      got = q.pop_front(); checks++;
      if ({clk_out, tick, pend} !== got)
        $display("FAIL areset_divreset k=%0d got c=%b t=%b p=%b want c=%b t=%b p=%b", k, clk_out, tick, pend, got.c, got.t, got.p);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_odd_divisors();
    test_mid_period();
    test_wrap_write();
    test_sync();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
